// File: rtl/meas_report_tx_pkg.sv
// Shared constants, FSM state type and checksum helper for the measurement report transmitter.
package meas_report_tx_pkg;

    localparam logic [7:0] HDR0      = 8'hA5;
    localparam logic [7:0] HDR1      = 8'h5A;
    localparam int         FRAME_LEN = 8;

    localparam logic [7:0] MOD_NONE = 8'd0;
    localparam logic [7:0] MOD_AM   = 8'd1;
    localparam logic [7:0] MOD_PSK  = 8'd2;
    localparam logic [7:0] MOD_FM   = 8'd3;
    localparam logic [7:0] MOD_FSK  = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } frame_state_t;

    function automatic logic [7:0] frame_chk(
        input logic [7:0]  mt,
        input logic [15:0] df,
        input logic [7:0]  md,
        input logic [7:0]  dl
    );
        return mt + df[15:8] + df[7:0] + md + dl;
    endfunction

endpackage

// File: rtl/meas_report_tx_uart_byte_tx.sv
// 8N1 byte serializer: valid/ready byte input, 10-bit shift register, bit-period down-counter.
module meas_report_tx_uart_byte_tx #(
    parameter int BIT_CLKS = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       uart_tx,
    output logic       byte_done
);

    localparam int              CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(BIT_CLKS - 1);

    logic [CW-1:0] bit_cnt;
    logic [3:0]    bits_left;
    logic [9:0]    shift_q;
    logic          active;
    logic          last_tick;

    // Ready during the final stop-bit cycle so the next byte follows with no idle gap.
    assign last_tick  = active && (bits_left == 4'd0) && (bit_cnt == '0);
    assign byte_ready = !active || last_tick;
    assign byte_done  = last_tick;
    assign uart_tx    = shift_q[0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            active    <= 1'b0;
            bit_cnt   <= '0;
            bits_left <= '0;
            shift_q   <= '1;
        end else if (byte_valid && byte_ready) begin
            active    <= 1'b1;
            shift_q   <= {1'b1, byte_data, 1'b0};
            bit_cnt   <= BIT_LAST;
            bits_left <= 4'd9;
        end else if (active) begin
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end else if (bits_left != 4'd0) begin
                shift_q   <= {1'b1, shift_q[9:1]};
                bits_left <= bits_left - 4'd1;
                bit_cnt   <= BIT_LAST;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/meas_report_tx.sv
// Periodic / on-request measurement snapshot, packed into an 8-byte checksummed frame and sent over UART.
//
// state   | meaning
// IDLE    | waiting for trigger or pending request
// LOAD    | latch snapshot and checksum, hand header byte 0 to the serializer
// SEND    | serializer busy; on each byte_done queue the next byte or finish
// DONE    | one-cycle frame_done pulse, then IDLE
module meas_report_tx
    import meas_report_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int REPORT_DIV = 5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  mod_type,
    input  logic [15:0] demod_fre,
    input  logic [7:0]  mod_depth,
    input  logic [7:0]  delta_freq,
    input  logic        send_req,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int            BIT_CLKS   = CLK_FREQ / BAUD;
    localparam int            TW         = $clog2(REPORT_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(FRAME_LEN - 1);

    frame_state_t  state_q, state_nxt;
    logic [TW-1:0] timer_q;
    logic          tick, trigger;
    logic          pending_q;
    logic [2:0]    idx_q;
    logic [2:0]    byte_sel;
    logic [7:0]    snap_mod_type, snap_mod_depth, snap_delta_freq, chk_q;
    logic [15:0]   snap_demod_fre;
    logic [15:0]   frame_cnt_q;
    logic [7:0]    byte_data;
    logic          byte_valid, byte_ready, byte_done;
    logic          last_byte_done;

    assign tick           = (timer_q == TIMER_LAST);
    assign trigger        = tick || send_req;
    assign last_byte_done = (state_q == ST_SEND) && byte_done && (idx_q == IDX_LAST);
    assign frame_cnt      = frame_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: if (trigger || pending_q) state_nxt = ST_LOAD;
            ST_LOAD: if (byte_ready) state_nxt = ST_SEND;
            ST_SEND: if (last_byte_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        byte_valid = 1'b0;
        byte_sel   = idx_q + 3'd1;
        unique case (state_q)
            ST_LOAD: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                byte_sel   = 3'd0;
            end
            ST_SEND: begin
                busy       = 1'b1;
                byte_valid = byte_done && (idx_q != IDX_LAST);
            end
            ST_DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

    // Byte 0 is a constant so LOAD can hand it over before the snapshot registers settle.
    always_comb begin
        unique case (byte_sel)
            3'd0:    byte_data = HDR0;
            3'd1:    byte_data = HDR1;
            3'd2:    byte_data = snap_mod_type;
            3'd3:    byte_data = snap_demod_fre[15:8];
            3'd4:    byte_data = snap_demod_fre[7:0];
            3'd5:    byte_data = snap_mod_depth;
            3'd6:    byte_data = snap_delta_freq;
            default: byte_data = chk_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer_q         <= '0;
            pending_q       <= 1'b0;
            idx_q           <= '0;
            snap_mod_type   <= '0;
            snap_demod_fre  <= '0;
            snap_mod_depth  <= '0;
            snap_delta_freq <= '0;
            chk_q           <= '0;
            frame_cnt_q     <= '0;
        end else begin
            timer_q <= tick ? '0 : timer_q + 1'b1;

            // Leaving IDLE always consumes the request; any trigger while a frame is active collapses into one.
            if (state_q == ST_IDLE) begin
                pending_q <= 1'b0;
            end else if (trigger) begin
                pending_q <= 1'b1;
            end

            if (state_q == ST_LOAD) begin
                snap_mod_type   <= mod_type;
                snap_demod_fre  <= demod_fre;
                snap_mod_depth  <= mod_depth;
                snap_delta_freq <= delta_freq;
                chk_q           <= frame_chk(mod_type, demod_fre, mod_depth, delta_freq);
                idx_q           <= '0;
            end else if (byte_valid && byte_ready) begin
                idx_q <= idx_q + 3'd1;
            end

            if (last_byte_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    meas_report_tx_uart_byte_tx #(
        .BIT_CLKS (BIT_CLKS)
    ) u_uart_byte_tx (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .uart_tx    (uart_tx),
        .byte_done  (byte_done)
    );

endmodule

// File: tb/tb_meas_report_tx.sv
// Scoreboard bench: a cycle-level request model predicts frames; a UART decoder checks them.
module tb_meas_report_tx;
    import meas_report_tx_pkg::*;

    localparam int BIT_CLKS   = 10;
    localparam int REPORT_DIV = 2000;
    localparam int BYTE_CLKS  = 10 * BIT_CLKS;
    localparam int FRAME_CLKS = 8 * BYTE_CLKS;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  mod_type = '0;
    logic [15:0] demod_fre = '0;
    logic [7:0]  mod_depth = '0;
    logic [7:0]  delta_freq = '0;
    logic        send_req = 1'b0;
    logic        uart_tx, busy, frame_done;
    logic [15:0] frame_cnt;

    meas_report_tx #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .REPORT_DIV (REPORT_DIV)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mod_type   (mod_type),
        .demod_fre  (demod_fre),
        .mod_depth  (mod_depth),
        .delta_freq (delta_freq),
        .send_req   (send_req),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    typedef struct { int start; logic [63:0] bytes; } frame_t;
    typedef struct { int cyc; logic [15:0] cnt; } done_t;
    frame_t exp_frames[$];
    done_t  exp_dones[$];

    // Reference frame built from field values with plain arithmetic.
    function automatic logic [63:0] build_frame(input int mt, input int df, input int md, input int dl);
        int b[8];
        logic [63:0] r;
        b[0] = 165;
        b[1] = 90;
        b[2] = mt;
        b[3] = df / 256;
        b[4] = df % 256;
        b[5] = md;
        b[6] = dl;
        b[7] = (mt + b[3] + b[4] + md + dl) % 256;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(b[k]);
        return r;
    endfunction

    // Request model: a frame occupies trigger cycle .. DONE+? ; the design is free again 803 cycles after the accepted trigger.
    int          mcyc = 0;
    int          free_at = 0;
    int          load_at = -1;
    bit          pend = 1'b0;
    bit          in_reset = 1'b0;
    bit          mon_on = 1'b0;
    logic [15:0] exp_cnt = '0;

    always @(posedge sys_clk) begin
        bit     trig;
        frame_t f;
        done_t  d;
        if (sys_rst) begin
            mcyc = 0; free_at = 0; load_at = -1; pend = 1'b0; exp_cnt = '0;
            exp_frames.delete();
            exp_dones.delete();
            in_reset = 1'b1;
            mon_on = 1'b1;
        end else begin
            in_reset = 1'b0;
            trig = ((mcyc % REPORT_DIV) == REPORT_DIV - 1) || send_req;
            if (mcyc == load_at) begin
                f.start = mcyc + 1;
                f.bytes = build_frame(int'(mod_type), int'(demod_fre), int'(mod_depth), int'(delta_freq));
                exp_frames.push_back(f);
                exp_cnt = exp_cnt + 16'd1;
                d.cyc = mcyc + 1 + FRAME_CLKS;
                d.cnt = exp_cnt;
                exp_dones.push_back(d);
            end
            if (mcyc >= free_at && (trig || pend)) begin
                pend = 1'b0;
                load_at = mcyc + 1;
                free_at = mcyc + 3 + FRAME_CLKS;
            end else if (mcyc < free_at && trig) begin
                pend = 1'b1;
            end
            mcyc++;
        end
    end

    // Monitor: decodes uart_tx at mid-bit and checks frame_done / frame_cnt.
    bit          active = 1'b0;
    bit          have_cur = 1'b0;
    bit          cnt_chk = 1'b0;
    int          bstart = 0;
    int          byte_k = 0;
    int          off = 0;
    logic [7:0]  shreg = '0;
    logic [15:0] cnt_exp = '0;
    frame_t      cur;
    done_t       dpop;

    always @(negedge sys_clk) begin
        if (mon_on) begin
            if (in_reset) begin
                active = 1'b0; byte_k = 0; have_cur = 1'b0; cnt_chk = 1'b0;
                chk("rst_uart_tx", 32'(uart_tx), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
            end else begin
                if (cnt_chk) begin
                    chk("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
                    cnt_chk = 1'b0;
                end
                if (frame_done) begin
                    if (exp_dones.size() == 0) begin
                        chk("unexpected_frame_done", 32'(exp_dones.size()), 32'd1);
                    end else begin
                        dpop = exp_dones.pop_front();
                        chk("done_cycle", 32'(mcyc), 32'(dpop.cyc));
                        chk("busy_at_done", 32'(busy), 32'd0);
                        cnt_exp = dpop.cnt;
                        cnt_chk = 1'b1;
                    end
                end
                if (!active) begin
                    if (uart_tx == 1'b0) begin
                        active = 1'b1;
                        bstart = mcyc;
                        if (byte_k == 0) begin
                            if (exp_frames.size() == 0) begin
                                have_cur = 1'b0;
                                chk("unexpected_frame_start", 32'(exp_frames.size()), 32'd1);
                            end else begin
                                cur = exp_frames.pop_front();
                                have_cur = 1'b1;
                                chk("frame_start", 32'(mcyc), 32'(cur.start));
                                chk("busy_in_frame", 32'(busy), 32'd1);
                            end
                        end else if (have_cur) begin
                            chk("byte_start", 32'(mcyc), 32'(cur.start + byte_k * BYTE_CLKS));
                        end
                    end
                end else begin
                    off = mcyc - bstart;
                    if (off == BIT_CLKS / 2) begin
                        chk("start_bit", 32'(uart_tx), 32'd0);
                    end else if (off > BIT_CLKS && off < 9 * BIT_CLKS && (off % BIT_CLKS) == BIT_CLKS / 2) begin
                        shreg = {uart_tx, shreg[7:1]};
                    end else if (off == 9 * BIT_CLKS + BIT_CLKS / 2) begin
                        chk("stop_bit", 32'(uart_tx), 32'd1);
                        if (have_cur) chk("frame_byte", 32'(shreg), 32'(cur.bytes[8*byte_k +: 8]));
                        byte_k = (byte_k + 1) % 8;
                    end else if (off == BYTE_CLKS - 1) begin
                        active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (mcyc < c) @(negedge sys_clk);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge sys_clk);
        send_req = 1'b0;
    endtask

    logic [7:0] codes [5];

    initial begin
        int guard;
        codes = '{MOD_NONE, MOD_AM, MOD_PSK, MOD_FM, MOD_FSK};

        // Directed request with known field values.
        do_reset();
        mod_type = MOD_FM; demod_fre = 16'h1F40; mod_depth = 8'h05; delta_freq = 8'h32;
        wait_until(5);
        pulse_req();
        wait_until(900);
        chk("s1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Periodic reports only.
        do_reset();
        wait_until(4900);
        chk("s2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Several requests during one frame collapse into one extra frame.
        do_reset();
        wait_until(5);   pulse_req();
        wait_until(100); pulse_req();
        wait_until(300); pulse_req();
        wait_until(500); pulse_req();
        wait_until(1700);
        chk("s3_frame_cnt", 32'(frame_cnt), 32'd2);

        // Snapshot isolation: input change mid-frame.
        do_reset();
        demod_fre = 16'h1234;
        wait_until(5);
        pulse_req();
        wait_until(207);
        demod_fre = 16'h0000;
        wait_until(900);

        // Reset 300 cycles into a second frame.
        demod_fre = 16'hBEEF;
        wait_until(905);
        pulse_req();
        wait_until(1207);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_until(1500);

        // frame_cnt wrap.
        do_reset();
        wait_until(3);
        force dut.frame_cnt_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(negedge sys_clk);
        release dut.frame_cnt_q;
        wait_until(5);
        pulse_req();
        wait_until(900);
        chk("s6_wrap", 32'(frame_cnt), 32'd0);

        // Randomized requests and input changes.
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                mod_type   = codes[$urandom_range(0, 4)];
                demod_fre  = 16'($urandom);
                mod_depth  = 8'($urandom);
                delta_freq = 8'($urandom);
            end
            send_req = ($urandom_range(0, 299) == 0);
            @(negedge sys_clk);
        end
        send_req = 1'b0;

        guard = 0;
        while (!(exp_frames.size() == 0 && exp_dones.size() == 0 && mcyc >= free_at && !pend && !active)
               && guard < 3000) begin
            @(negedge sys_clk);
            guard++;
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("drain_outstanding", 32'(exp_frames.size() + exp_dones.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
